// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared types and widths for the sequential 4xN approximate multiplier
package approx_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int PP_A_W = 4;
    localparam int PP_B_W = 2;
    localparam int PP_P_W = 6;

    function automatic int calc_p_width(input int b_width);
        return PP_A_W + b_width;
    endfunction

endpackage

// File: rtl/approx_mult_seq_4xn.sv
// rtl/approx_mult_seq_4xn.sv - iterative 4 x B_WIDTH controller around an external 4x2 partial-product multiplier
module approx_mult_seq_4xn
    import approx_mult_pkg::*;
#(
    parameter  int B_WIDTH = 8,
    localparam int P_WIDTH = calc_p_width(B_WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [PP_A_W-1:0]   a_i,
    input  logic [B_WIDTH-1:0]  b_i,
    output logic [PP_A_W-1:0]   pp_a_o,
    output logic [PP_B_W-1:0]   pp_b_o,
    input  logic [PP_P_W-1:0]   pp_prod_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [P_WIDTH-1:0]  prod_o,
    output logic                ovf_o
);

    localparam int N_STEPS = B_WIDTH / 2;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PP_A_W-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]  b_q, b_d;
    logic [P_WIDTH-1:0]  acc_q, acc_d;
    logic                ovf_q, ovf_d;

    // One guard bit above the result: the shifted product never exceeds P_WIDTH bits,
    // so any carry out of the add lands exactly in sum[P_WIDTH].
    logic [CNT_W:0]      bit_idx;
    logic [P_WIDTH:0]    pp_shift;
    logic [P_WIDTH:0]    sum;

    always_comb begin
        bit_idx  = {cnt_q, 1'b0};
        pp_shift = {{(P_WIDTH + 1 - PP_P_W){1'b0}}, pp_prod_i} << bit_idx;
        sum      = {1'b0, acc_q} + pp_shift;

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = sum[P_WIDTH-1:0];
                if (sum[P_WIDTH]) begin
                    ovf_d = 1'b1;
                end
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign pp_a_o      = a_q;
    assign pp_b_o      = (state_q == ST_RUN) ? b_q[bit_idx +: PP_B_W] : '0;
    assign prod_o      = acc_q;
    assign ovf_o       = ovf_q;

endmodule
